demux_18_seq: RTL and testbench
===============================

# demux_18_seq

Registered 1-to-8 demultiplexer, the inverse of the team's 8:1 select tree: routes a single-bit input stream onto eight output lines. Addressed mode writes the bit to the line selected by `{a2,a1,a0}`. Auto mode steps an internal pointer 0→7, collecting eight bits into a word and presenting it through a valid/ready handshake. It sits upstream of the 8:1 mux paths in loopback and serial-to-parallel datapaths.

## Interface
- `RESET_VAL`, default `8'h00`: reset and clear value of `y`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous reset, active-high.
- `clr` input 1: synchronous clear of `y`, `ptr` and `word_valid`; lower priority than `rst`.
- `din` input 1: serial data bit.
- `din_valid` input 1: `din` is presented this cycle.
- `din_ready` output 1: block accepts `din` this cycle; a transfer occurs when `din_valid && din_ready`.
- `mode` input 1: 0 = addressed, 1 = auto-sequence.
- `a2`, `a1`, `a0` input 1 each: line select in addressed mode; `a2` is the MSB.
- `y` output 8: registered demux outputs.
- `strobe` output 8: one-hot, one-cycle pulse marking the line written by the previous transfer.
- `word` output 8: collected word in auto mode.
- `word_valid` output 1: `word` is valid and held stable until it is accepted.
- `word_ready` input 1: downstream accepts `word` when `word_valid && word_ready`.
- `overflow` output 1: sticky error flag; cleared only by `rst` or `clr`.

## Operation
- States:
  - IDLE: `mode` = 0, or `mode` = 1 with `ptr` = 0.
  - FILL: auto mode with `ptr` ≠ 0.
  - The output register `word_valid` is a separate flag.
- Addressed mode transfer:
  - `y[{a2,a1,a0}] <= din`; all other `y` bits hold.
  - `strobe` asserts bit `{a2,a1,a0}` next cycle.
  - `ptr` is forced to 0 and `word_valid` is unaffected.
- Auto mode transfer:
  - `y[ptr] <= din` and `strobe[ptr]` pulses.
  - `ptr` increments modulo 8.
  - The `a*` inputs are ignored.
- 8th bit (`ptr` = 7):
  - `word <= {din, y[6:0]}`, i.e. the word including the new bit.
  - `word_valid <= 1` and `ptr` wraps to 0.
- Bit order: the first auto bit lands in `y[0]`, the eighth in `y[7]`.
- `din_ready`:
  - Always 1 in addressed mode.
  - In auto mode, `din_ready = !(word_valid && !word_ready && ptr == 7)`. Only the completing bit stalls, so one word can be held while the next fills.
- Simultaneous completion and accept: if the 8th bit completes the same cycle that `word_valid && word_ready`, the new word loads and `word_valid` stays 1.
- Accept without completion clears `word_valid`.
- Overflow: asserts if a frame-completing transfer is attempted (`din_valid`, auto mode, `ptr` = 7) while `din_ready` = 0. The bit is not consumed and the source must hold it.
- Mode switch mid-frame: on a 1→0 switch, `ptr` clears immediately and the partial frame is abandoned; `y` keeps the bits already written.
- Reset values:
  - `y` = `RESET_VAL`.
  - `strobe`, `word`, `word_valid` and `overflow` = 0.
  - `ptr` = 0.
- `clr` gives the same result as reset, except `word` holds its value.
- `rst` or `clr` during FILL discards the partial frame.

## Timing
- `y`, `strobe`, `word`, `word_valid` and `overflow` are registered and update one cycle after the causing transfer.
- `din_ready` is combinational from `mode`, `ptr`, `word_valid` and `word_ready`. There is no combinational path from `din` or `din_valid`.
- Auto-mode latency: 8 accepted transfers, then `word_valid` rises on the following edge. Back-to-back input gives one word per 8 cycles with no bubble.
- `strobe` is all-zero in any cycle not preceded by a transfer.

## Test plan
- Addressed writes: `din` = 1 with `{a2,a1,a0}` = 5, then `din` = 1 with 2, from reset. Required: `y` = `8'h20` then `8'h24`; `strobe` = `8'h20` then `8'h04`, each a single-cycle pulse.
- Auto collect: bits 1,0,1,1,0,0,1,0 with `din_valid` continuous and `word_ready` = 1. Required: `word` = `8'h4D` and `word_valid` high exactly one cycle after the 8th bit.
- Backpressure: `word_ready` = 0 and two full frames `8'hA5` then `8'h3C` sent back-to-back.
  - Required: `din_ready` drops at the 16th bit and `word` holds `8'hA5`.
  - Raising `word_ready` for one cycle accepts `8'hA5` and takes the 16th bit; `word` = `8'h3C` the next cycle; `overflow` stays 0.
- Overflow: repeat the backpressure case with `din_valid` held at the stall. Required: `overflow` = 1 and stays 1 until `clr`.
- Mode switch: after 3 auto bits (`ptr` = 3), set `mode` = 0 for one addressed write, then return to `mode` = 1. Required: the next auto bit lands in `y[0]` (`ptr` restarted).
- Reset mid-frame: `rst` after 5 auto bits. Required: `y` = `RESET_VAL`, `word_valid` = 0, and the next frame completes after exactly 8 bits.

Source files
------------

// File: rtl/demux_18_seq.sv
`default_nettype none
// ============================================================================
//  Module      : demux_18_seq
//  Description : Registered 1-to-8 demultiplexer for a serial bit stream.
//                Addressed mode (mode=0) writes din into y[{a2,a1,a0}].
//                Auto mode (mode=1) steps an internal pointer 0..7, so the
//                first bit lands in y[0] and the eighth in y[7]. It then
//                presents the assembled byte on `word` through a
//                valid/ready handshake.
//
//  Ports
//    clk, rst            : clock, synchronous active-high reset
//    clr                 : synchronous clear of y/ptr/word_valid/overflow
//                          (word holds its value); lower priority than rst
//    din, din_valid      : serial input bit and its qualifier
//    din_ready           : combinational accept (mode, ptr, word_valid,
//                          word_ready only)
//    mode                : 0 = addressed, 1 = auto-sequence
//    a2, a1, a0          : line select in addressed mode (a2 = MSB)
//    y                   : registered demux outputs
//    strobe              : one-hot pulse for the line written by the
//                          previous transfer
//    word, word_valid,
//    word_ready          : collected byte and its handshake
//    overflow            : sticky flag; set when a frame-completing bit is
//                          offered while the held word blocks it
//
//  Revision    : 1.0  initial release
// ============================================================================
module demux_18_seq #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       mode,
    input  logic       a2,
    input  logic       a1,
    input  logic       a0,
    output logic [7:0] y,
    output logic [7:0] strobe,
    output logic [7:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       overflow
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;
    localparam logic [2:0] c_LAST = 3'd7;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_ptr;
    logic [7:0] r_y;
    logic [7:0] r_strobe;
    logic [7:0] r_word;
    logic       r_word_valid;
    logic       r_overflow;

    logic       w_din_ready;
    logic       w_last;
    logic       w_xfer;
    logic       w_complete;
    logic       w_accept;
    logic [2:0] w_idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: FILL while a partial auto frame is in progress.
    // Leaving auto mode abandons the frame.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!mode) begin
            w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
            w_state_nxt = (r_ptr == c_LAST) ? S_IDLE : S_FILL;
        end
    end

    // ------------------------------------------------------------------
    // Output / control logic
    // ------------------------------------------------------------------
    always_comb begin
        w_last      = (r_state == S_FILL) && (r_ptr == c_LAST);
        // Only the frame-completing bit stalls: the next frame may fill
        // while the previous word is still waiting to be accepted.
        w_din_ready = !mode || !(r_word_valid && !word_ready && w_last);
        w_xfer      = din_valid && w_din_ready;
        w_complete  = mode && w_xfer && w_last;
        w_accept    = r_word_valid && word_ready;
        w_idx       = mode ? r_ptr : {a2, a1, a0};
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y          <= RESET_VAL;
            r_strobe     <= 8'h00;
            r_word       <= 8'h00;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_ptr        <= 3'd0;
        end else if (clr) begin
            r_y          <= RESET_VAL;
            r_strobe     <= 8'h00;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_ptr        <= 3'd0;
        end else begin
            r_strobe <= w_xfer ? (8'h01 << w_idx) : 8'h00;

            if (w_xfer) begin
                r_y[w_idx] <= din;
            end

            if (!mode) begin
                r_ptr <= 3'd0;
            end else if (w_xfer) begin
                r_ptr <= r_ptr + 3'd1;
            end

            // A completion in the same cycle as an accept reloads the word,
            // so word_valid stays high.
            if (w_complete) begin
                r_word       <= {din, r_y[6:0]};
                r_word_valid <= 1'b1;
            end else if (w_accept) begin
                r_word_valid <= 1'b0;
            end

            if (mode && din_valid && w_last && !w_din_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign din_ready  = w_din_ready;
    assign y          = r_y;
    assign strobe     = r_strobe;
    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_demux_18_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_18_seq
//  Description : Directed self-checking bench for demux_18_seq. Inputs are
//                driven 1 time unit after the rising edge; registered
//                outputs are sampled at the same point after the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_18_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       mode;
    logic       a2;
    logic       a1;
    logic       a0;
    logic [7:0] y;
    logic [7:0] strobe;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    demux_18_seq #(.RESET_VAL(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mode       (mode),
        .a2         (a2),
        .a1         (a1),
        .a0         (a0),
        .y          (y),
        .strobe     (strobe),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer attempt; din_valid drops afterwards unless the next
    // call re-asserts it at the same instant.
    task automatic send_bit(input logic m, input logic d, input logic [2:0] a);
        mode      = m;
        din       = d;
        {a2, a1, a0} = a;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Auto-mode bits b[0] .. b[n-1], back to back.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1, b[i], 3'd0);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; din = 1'b0; din_valid = 1'b0; mode = 1'b0;
        a2 = 1'b0; a1 = 1'b0; a0 = 1'b0; word_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_y", y, 8'h00);
        chk("rst_strobe", strobe, 8'h00);
        chk("rst_word", word, 8'h00);
        chk("rst_word_valid", {7'd0, word_valid}, 8'h00);
        chk("rst_overflow", {7'd0, overflow}, 8'h00);
        chk("rst_din_ready", {7'd0, din_ready}, 8'h01);

        // Addressed writes: line 5 then line 2
        send_bit(1'b0, 1'b1, 3'd5);
        chk("addr5_y", y, 8'h20);
        chk("addr5_strobe", strobe, 8'h20);
        send_bit(1'b0, 1'b1, 3'd2);
        chk("addr2_y", y, 8'h24);
        chk("addr2_strobe", strobe, 8'h04);
        tick();
        chk("addr_strobe_gone", strobe, 8'h00);
        chk("addr_y_hold", y, 8'h24);

        // Auto collect 8'h4D with word_ready high
        word_ready = 1'b1;
        send_bits(8'h4D, 7);
        chk("auto_wv_before_8th", {7'd0, word_valid}, 8'h00);
        send_bit(1'b1, 1'b0, 3'd0);
        chk("auto_word", word, 8'h4D);
        chk("auto_wv", {7'd0, word_valid}, 8'h01);
        chk("auto_y", y, 8'h4D);
        chk("auto_strobe7", strobe, 8'h80);
        tick();
        chk("auto_accept_clears", {7'd0, word_valid}, 8'h00);

        // Backpressure: A5 then 3C with word_ready low
        word_ready = 1'b0;
        send_bits(8'hA5, 8);
        chk("bp_word_a5", word, 8'hA5);
        chk("bp_wv", {7'd0, word_valid}, 8'h01);
        send_bits(8'h3C, 7);
        mode = 1'b1; din = 1'b0; din_valid = 1'b0;
        #1;
        chk("bp_stall_ready", {7'd0, din_ready}, 8'h00);
        tick();
        chk("bp_word_hold", word, 8'hA5);
        din_valid = 1'b1; word_ready = 1'b1;
        #1;
        chk("bp_ready_on_accept", {7'd0, din_ready}, 8'h01);
        tick();
        din_valid = 1'b0; word_ready = 1'b0;
        chk("bp_word_3c", word, 8'h3C);
        chk("bp_wv_stays", {7'd0, word_valid}, 8'h01);
        chk("bp_no_overflow", {7'd0, overflow}, 8'h00);

        // Overflow: same as above but din_valid held at the stall
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_word_holds", word, 8'h3C);
        chk("clr_wv", {7'd0, word_valid}, 8'h00);
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 7);
        send_bit(1'b1, 1'b0, 3'd0);
        chk("ovf_set", {7'd0, overflow}, 8'h01);
        chk("ovf_word_held", word, 8'hA5);
        mode = 1'b1; din = 1'b0; din_valid = 1'b1; word_ready = 1'b1;
        tick();
        din_valid = 1'b0; word_ready = 1'b0;
        chk("ovf_word_3c", word, 8'h3C);
        tick();
        tick();
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_cleared", {7'd0, overflow}, 8'h00);
        chk("ovf_clr_y", y, 8'h00);
        chk("ovf_clr_word", word, 8'h3C);

        // Mode switch mid-frame restarts the pointer
        word_ready = 1'b1;
        send_bits(8'h07, 3);
        chk("ms_y_3bits", y, 8'h07);
        send_bit(1'b0, 1'b1, 3'd6);
        chk("ms_addr_y", y, 8'h47);
        send_bit(1'b1, 1'b0, 3'd0);
        chk("ms_restart_y", y, 8'h46);
        chk("ms_restart_strobe", strobe, 8'h01);

        // Reset mid-frame
        send_bits(8'hFF, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmf_y", y, 8'h00);
        chk("rmf_wv", {7'd0, word_valid}, 8'h00);
        send_bits(8'h96, 7);
        chk("rmf_wv_after7", {7'd0, word_valid}, 8'h00);
        send_bit(1'b1, 1'b1, 3'd0);
        chk("rmf_wv_after8", {7'd0, word_valid}, 8'h01);
        chk("rmf_word", word, 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
